// File: rtl/sw_debounce.sv
// Switch synchroniser and per-bit debouncer with registered rise/fall/change pulses.
// Define SW_DEBOUNCE_BYPASS_EN to drop the debounce counters (sw_out follows sync directly).
module sw_debounce #(
  parameter int WIDTH       = 8,
  parameter int CNT_MAX     = 200000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic             sw_change,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall
);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_out_next;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic             r_change;

  // Plain flop chain per bit, no logic between stages.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_sync[s] <= '0;
      end
    end else begin
      r_sync[0] <= sw_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef SW_DEBOUNCE_BYPASS_EN
  assign w_out_next = w_sync;
`else
  localparam int             CW       = $clog2(CNT_MAX);
  localparam logic [CW-1:0]  CNT_LAST = CW'(CNT_MAX - 1);

  logic [CW-1:0]    r_cnt      [WIDTH];
  logic [CW-1:0]    w_cnt_next [WIDTH];
  logic [WIDTH-1:0] w_upd;

  // Any match clears the run, so short glitches earn no partial credit.
  always_comb begin
    w_upd = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_cnt_next[i] = '0;
      if (w_sync[i] == r_out[i]) begin
        w_cnt_next[i] = '0;
      end else if (r_cnt[i] == CNT_LAST) begin
        w_upd[i]      = 1'b1;
        w_cnt_next[i] = '0;
      end else begin
        w_cnt_next[i] = r_cnt[i] + CW'(1);
      end
    end
  end

  // Per-bit mismatch run counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= w_cnt_next[i];
      end
    end
  end

  assign w_out_next = r_out ^ w_upd;
`endif

  // Edge masks are computed from the same next value so they line up with sw_out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out    <= '0;
      r_rise   <= '0;
      r_fall   <= '0;
      r_change <= 1'b0;
    end else begin
      r_out    <= w_out_next;
      r_rise   <= w_out_next & ~r_out;
      r_fall   <= ~w_out_next & r_out;
      r_change <= |(w_out_next ^ r_out);
    end
  end

  assign sw_out    = r_out;
  assign sw_rise   = r_rise;
  assign sw_fall   = r_fall;
  assign sw_change = r_change;

endmodule

// File: tb/tb_sw_debounce.sv
// Randomised and directed bench for sw_debounce against a sample-window reference model.
module tb_sw_debounce;

  localparam int WIDTH       = 8;
  localparam int CNT_MAX     = 4;
  localparam int SYNC_STAGES = 2;
`ifdef SW_DEBOUNCE_BYPASS_EN
  localparam int M_CNT = 1;
`else
  localparam int M_CNT = CNT_MAX;
`endif
  localparam int LAT = SYNC_STAGES + M_CNT;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] sw_in;
  logic [WIDTH-1:0] sw_out;
  logic             sw_change;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;

  int checks = 0;
  int errors = 0;

  // Model: a bit flips when the last M_CNT samples seen through the synchroniser delay all differ from it.
  logic [WIDTH-1:0] hist [$];
  logic [WIDTH-1:0] m_out, m_rise, m_fall;
  logic             m_chg;
  int               dut_r7, mod_r7;

  sw_debounce #(.WIDTH(WIDTH), .CNT_MAX(CNT_MAX), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk      (clk),
    .reset    (reset),
    .sw_in    (sw_in),
    .sw_out   (sw_out),
    .sw_change(sw_change),
    .sw_rise  (sw_rise),
    .sw_fall  (sw_fall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist = {};
    for (int k = 0; k < SYNC_STAGES + M_CNT; k++) hist.push_back('0);
    m_out  = '0;
    m_rise = '0;
    m_fall = '0;
    m_chg  = 1'b0;
  endtask

  task automatic model_edge(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] nxt;
    bit               all_diff;
    hist.push_back(s);
    if (hist.size() > 32) void'(hist.pop_front());
    nxt = m_out;
    for (int b = 0; b < WIDTH; b++) begin
      all_diff = 1'b1;
      for (int j = 0; j < M_CNT; j++) begin
        if (hist[hist.size() - 1 - SYNC_STAGES - j][b] == m_out[b]) all_diff = 1'b0;
      end
      if (all_diff) nxt[b] = ~m_out[b];
    end
    m_rise = nxt & ~m_out;
    m_fall = ~nxt & m_out;
    m_chg  = |(m_rise | m_fall);
    m_out  = nxt;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(sw_in);
    @(negedge clk);
    check("out",    sw_out,  m_out);
    check("rise",   sw_rise, m_rise);
    check("fall",   sw_fall, m_fall);
    check("change", {7'd0, sw_change}, {7'd0, m_chg});
    if (sw_rise[7]) dut_r7++;
    if (m_rise[7])  mod_r7++;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out"},  sw_out,  8'h00);
    check({tag, "_rise"}, sw_rise, 8'h00);
    check({tag, "_fall"}, sw_fall, 8'h00);
    check({tag, "_chg"},  {7'd0, sw_change}, 8'h00);
  endtask

  initial begin
    reset = 1'b1;
    sw_in = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    // Power-up with a nonzero level.
    sw_in = 8'h5A;
    repeat (LAT - 1) step();
    check("pu_early", sw_out, 8'h00);
    step();
    check("pu_out",  sw_out,  8'h5A);
    check("pu_rise", sw_rise, 8'h5A);
    check("pu_fall", sw_fall, 8'h00);
    check("pu_chg",  {7'd0, sw_change}, 8'h01);
    step();
    check("pu_pulse_end", {7'd0, sw_change}, 8'h00);

    // Three-cycle glitch on bit0.
    sw_in = 8'h5B;
    repeat (3) step();
    sw_in = 8'h5A;
    repeat (8) step();
`ifndef SW_DEBOUNCE_BYPASS_EN
    check("glitch_out", sw_out, 8'h5A);
`endif

    // Every bit flips together.
    sw_in = 8'hA5;
    repeat (LAT - 1) step();
    check("flip_early", sw_out, 8'h5A);
    step();
    check("flip_out",  sw_out,  8'hA5);
    check("flip_rise", sw_rise, 8'hA5);
    check("flip_fall", sw_fall, 8'h5A);
    check("flip_chg",  {7'd0, sw_change}, 8'h01);
    step();

    // Bounce bit7 from a settled 0.
    sw_in = 8'h25;
    repeat (8) step();
    dut_r7 = 0;
    mod_r7 = 0;
    sw_in = 8'hA5; step();
    sw_in = 8'h25; step();
    sw_in = 8'hA5; step();
    sw_in = 8'h25; step();
    sw_in = 8'hA5;
    repeat (10) step();
    check("bounce_rises", 8'(dut_r7), 8'(mod_r7));
`ifndef SW_DEBOUNCE_BYPASS_EN
    check("bounce_one", 8'(dut_r7), 8'd1);
`endif
    check("bounce_out", sw_out, 8'hA5);

    // Random levels held for random durations, including sub-threshold glitches.
    for (int seg = 0; seg < 60; seg++) begin
      sw_in = 8'($urandom);
      repeat ($urandom_range(1, 8)) step();
    end

    // Reset while a change is in progress.
    sw_in = 8'h00;
    repeat (10) step();
    sw_in = 8'hFF;
    repeat (4) step();
    reset = 1'b1;
    #1;
    check_all_zero("rst_mid");
    repeat (2) @(negedge clk);
    check_all_zero("rst_hold");
    reset = 1'b0;
    model_reset();
    repeat (LAT - 1) step();
    check("rel_early", sw_out, 8'h00);
    step();
    check("rel_out",  sw_out,  8'hFF);
    check("rel_rise", sw_rise, 8'hFF);
    step();

    // Reset with a nonzero stable output.
    reset = 1'b1;
    #1;
    check_all_zero("rst_nz");
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    sw_in = 8'h00;
    repeat (LAT + 2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
